// File: rtl/step_if.sv
// Bundle of the step sequencer's request, load and state signals.
// The slave modport is the sequencer. The master modport is the environment:
// the requesters plus the combinational next-state logic that returns next_y.
interface step_if #(
    parameter int CNT_W = 8
);
    logic             man_req;
    logic             man_s;
    logic             man_ack;
    logic             auto_en;
    logic             auto_s;
    logic             load;
    logic [3:0]       load_val;
    logic [3:0]       next_y;
    logic [3:0]       y;
    logic             s;
    logic             busy;
    logic [CNT_W-1:0] step_cnt;
    logic             auto_ovf;

    modport master (
        output man_req, man_s, auto_en, auto_s, load, load_val, next_y,
        input  man_ack, y, s, busy, step_cnt, auto_ovf
    );

    modport slave (
        input  man_req, man_s, auto_en, auto_s, load, load_val, next_y,
        output man_ack, y, s, busy, step_cnt, auto_ovf
    );
endinterface

// File: rtl/step_sequencer.sv
// Owns the 4-bit state register y and sequences every update of it through the
// external next-state logic. The step resource is shared round-robin between a
// handshaked manual requester and a free-running auto ticker. A load can
// overwrite y at any time and aborts a step that is in flight.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; a load or an arbitration grant happens here
// SETUP | s is presented to the next-state logic; y commits on exit
// HOLD  | enforced idle gap after a commit; requests accumulate
module step_sequencer #(
    parameter int TICK_DIV    = 50000000,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic  clk_i,
    input  logic  reset_i,
    step_if.slave bus
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, HOLD} state_t;

    state_t           state_q;
    logic [3:0]       y_q;
    logic             s_q;
    logic             man_ack_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic             auto_ovf_q;
    logic             auto_pend_q;
    logic             last_man_q;
    logic             win_man_q;
    logic [TW-1:0]    tick_cnt_q;
    logic [HW-1:0]    hold_cnt_q;

    logic             man_pend;
    logic             tick_wrap;
    logic             idle_free;
    logic             take_man;
    logic             take_auto;
    logic             auto_pend_d;
    logic             auto_ovf_d;

    // Arbitration and auto-pending bookkeeping. The tick counter runs downwards,
    // so a wrap is the terminal count at zero while enabled. A request still high
    // during its ack cycle is ignored so one request yields exactly one step.
    always_comb begin
        man_pend    = bus.man_req & ~man_ack_q;
        tick_wrap   = bus.auto_en & (tick_cnt_q == '0);
        idle_free   = (state_q == IDLE) & ~bus.load;
        take_man    = idle_free & man_pend & (~auto_pend_q | ~last_man_q);
        take_auto   = idle_free & auto_pend_q & (~man_pend | last_man_q);
        auto_pend_d = auto_pend_q;
        auto_ovf_d  = auto_ovf_q;
        if ((state_q == IDLE) && bus.load) begin
            auto_pend_d = 1'b0;
            auto_ovf_d  = 1'b0;
        end else if (take_auto) begin
            auto_pend_d = 1'b0;
        end
        // Overflow only if the pending step survives this edge; a grant on the
        // same edge as the tick consumes the old step first.
        if (tick_wrap) begin
            if (auto_pend_d) begin
                auto_ovf_d = 1'b1;
            end
            auto_pend_d = 1'b1;
        end
    end

    // Sequencer FSM, ticker and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            y_q         <= '0;
            s_q         <= 1'b0;
            man_ack_q   <= 1'b0;
            step_cnt_q  <= '0;
            auto_ovf_q  <= 1'b0;
            auto_pend_q <= 1'b0;
            last_man_q  <= 1'b0;
            win_man_q   <= 1'b0;
            tick_cnt_q  <= TICK_LAST;
            hold_cnt_q  <= '0;
        end else begin
            auto_pend_q <= auto_pend_d;
            auto_ovf_q  <= auto_ovf_d;
            man_ack_q   <= 1'b0;

            if (!bus.auto_en || tick_wrap) begin
                tick_cnt_q <= TICK_LAST;
            end else begin
                tick_cnt_q <= tick_cnt_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        y_q <= bus.load_val;
                    end else if (take_man || take_auto) begin
                        s_q        <= take_man ? bus.man_s : bus.auto_s;
                        last_man_q <= take_man;
                        win_man_q  <= take_man;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (bus.load) begin
                        y_q     <= bus.load_val;
                        state_q <= IDLE;
                    end else begin
                        y_q        <= bus.next_y;
                        step_cnt_q <= step_cnt_q + CNT_W'(1);
                        man_ack_q  <= win_man_q;
                        if (HOLD_CYCLES > 0) begin
                            hold_cnt_q <= HOLD_LAST;
                            state_q    <= HOLD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (bus.load) begin
                        y_q     <= bus.load_val;
                        state_q <= IDLE;
                    end else if (hold_cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.y        = y_q;
    assign bus.s        = s_q;
    assign bus.man_ack  = man_ack_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.step_cnt = step_cnt_q;
    assign bus.auto_ovf = auto_ovf_q;
endmodule
